mem_stage_ctrl: RTL and testbench

- Memory-stage controller plus M/W pipeline register for the MIPS pipeline.
- Consumes the E/M pipeline register outputs and performs the data-memory access over a req/ack bus, which may insert wait states.
- Drives StallM to freeze the upstream stages while the access is outstanding, then registers the result into the W stage.
- Detects a hung bus with a wait-cycle timeout.

---
 rtl/mips_pkg.sv | 8 +
 rtl/mem_wait_timer.sv | 27 ++
 rtl/mem_stage_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS memory-stage logic.
package mips_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int COUNTER_W  = 8;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-state counter; expired once the count reaches the timeout.
module mem_wait_timer
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);
    localparam logic [COUNTER_W-1:0] LIMIT = COUNTER_W'(TIMEOUT_CYCLES);

    logic [COUNTER_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc && r_count != LIMIT)
            r_count <= r_count + 1'b1;
    end

    assign o_expired = (r_count == LIMIT);
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: data-memory access over req/ack with wait states,
// upstream stall, bus-error timeout, and the M/W pipeline register.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     ALUOutM,
    input  logic [DATA_W-1:0]     WriteDataM,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  MemWriteM,
    output logic                  DMemReq,
    output logic                  DMemWe,
    output logic [DATA_W-1:0]     DMemAddr,
    output logic [DATA_W-1:0]     DMemWData,
    input  logic [DATA_W-1:0]     DMemRData,
    input  logic                  DMemAck,
    output logic                  StallM,
    output logic [DATA_W-1:0]     ALUOutW,
    output logic [DATA_W-1:0]     ReadDataW,
    output logic [REG_ADDR_W-1:0] WriteRegW,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic                  BusErrM
);
    state_t r_state, w_next;

    logic [DATA_W-1:0]     r_hold_alu, r_hold_wdata;
    logic [REG_ADDR_W-1:0] r_hold_wreg;
    logic                  r_hold_rw, r_hold_mtr, r_hold_we;

    logic                  w_access, w_capture, w_abort, w_inc, w_clr, w_expired;
    logic [DATA_W-1:0]     w_src_alu, w_rdata;
    logic [REG_ADDR_W-1:0] w_src_wreg;
    logic                  w_src_rw, w_src_mtr;

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .o_expired (w_expired)
    );

    always_comb begin
        w_access  = MemWriteM | MemtoRegM;
        w_next    = r_state;
        DMemReq   = 1'b0;
        DMemWe    = MemWriteM;
        DMemAddr  = ALUOutM;
        DMemWData = WriteDataM;
        StallM    = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        w_inc     = 1'b0;
        w_clr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                DMemReq = w_access;
                if (w_access && !DMemAck) begin
                    StallM    = 1'b1;
                    w_capture = 1'b1;
                    w_inc     = 1'b1;
                    w_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                DMemReq   = 1'b1;
                DMemWe    = r_hold_we;
                DMemAddr  = r_hold_alu;
                DMemWData = r_hold_wdata;
                if (DMemAck) begin
                    w_clr  = 1'b1;
                    w_next = S_IDLE;
                end else if (w_expired) begin
                    // abort still presents req this cycle; a late ack is then ignored
                    w_clr   = 1'b1;
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    StallM = 1'b1;
                    w_inc  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        if (r_state == S_WAIT) begin
            w_src_alu  = r_hold_alu;
            w_src_wreg = r_hold_wreg;
            w_src_rw   = r_hold_rw;
            w_src_mtr  = r_hold_mtr;
        end else begin
            w_src_alu  = ALUOutM;
            w_src_wreg = WriteRegM;
            w_src_rw   = RegWriteM;
            w_src_mtr  = MemtoRegM;
        end
        w_rdata = '0;
        if (w_abort)
            w_rdata = ERR_RDATA;
        else if (w_src_mtr)
            w_rdata = DMemRData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_hold_alu   <= '0;
            r_hold_wdata <= '0;
            r_hold_wreg  <= '0;
            r_hold_rw    <= 1'b0;
            r_hold_mtr   <= 1'b0;
            r_hold_we    <= 1'b0;
            BusErrM      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_hold_alu   <= ALUOutM;
                r_hold_wdata <= WriteDataM;
                r_hold_wreg  <= WriteRegM;
                r_hold_rw    <= RegWriteM;
                r_hold_mtr   <= MemtoRegM;
                r_hold_we    <= MemWriteM;
            end
            if (w_abort)
                BusErrM <= 1'b1;
        end
    end

    // While stalled the W stage sees a bubble: write enables drop, data holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUOutW   <= '0;
            ReadDataW <= '0;
            WriteRegW <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else begin
            ALUOutW   <= w_src_alu;
            ReadDataW <= w_rdata;
            WriteRegW <= w_src_wreg;
            RegWriteW <= w_src_rw;
            MemtoRegW <= w_src_mtr;
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: driver issues ops and a memory model,
// a negedge monitor checks each W-stage retirement against the queue.
module tb_mem_stage_ctrl;
    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ALUOutM = '0, WriteDataM = '0, DMemRData = '0;
    logic [4:0]  WriteRegM = '0;
    logic        RegWriteM = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0, DMemAck = 1'b0;
    logic        DMemReq, DMemWe, StallM, RegWriteW, MemtoRegW, BusErrM;
    logic [31:0] DMemAddr, DMemWData, ALUOutW, ReadDataW;
    logic [4:0]  WriteRegW;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
        .DMemRData(DMemRData), .DMemAck(DMemAck), .StallM(StallM),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .BusErrM(BusErrM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  wr;
        logic        rw, mtr, berr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0;
    logic exp_berr = 1'b0;
    bit   pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the op's retire edge.
    task automatic run_op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                          input logic rw, input logic mtr, input logic mw, input int n,
                          input logic [31:0] rd, input bit tmo, input bit stray);
        logic acc;
        exp_t e;
        int   stalls;
        int   k;
        bit   done;
        acc = mtr | mw;
        ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
        RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw;
        if (acc && tmo) exp_berr = 1'b1;
        e.alu = alu; e.wr = wr; e.rw = rw; e.mtr = mtr; e.berr = exp_berr;
        e.rdata = mtr ? (tmo ? ERR : rd) : 32'h0;
        exp_q.push_back(e);
        stalls = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            done = !acc || (!tmo && cyc == n) || (tmo && cyc == TMO);
            if (cyc > 0) begin
                ALUOutM = $urandom; WriteDataM = $urandom; WriteRegM = 5'($urandom);
                RegWriteM = 1'($urandom);
                k = $urandom_range(0, 2);
                MemtoRegM = (k == 1); MemWriteM = (k == 2);
            end
            DMemAck   = stray ? 1'b1 : (acc && !tmo && cyc == n);
            DMemRData = (acc && DMemAck) ? rd : $urandom;
            #1;
            chk("dmem_req", 32'(DMemReq), 32'(acc));
            if (acc) begin
                chk("dmem_addr", DMemAddr, alu);
                chk("dmem_wdata", DMemWData, wd);
                chk("dmem_we", 32'(DMemWe), 32'(mw));
            end
            chk("stall", 32'(StallM), 32'(!done));
            if (StallM) stalls++;
            @(posedge clk); #1;
            if (done) break;
        end
        chk("stall_cycles", 32'(stalls), acc ? (tmo ? 32'(TMO) : 32'(n)) : 32'h0);
    endtask

    task automatic rand_ops(input int cnt);
        int k;
        for (int i = 0; i < cnt; i++) begin
            k = $urandom_range(0, 2);
            run_op($urandom, $urandom, 5'($urandom), 1'($urandom), k == 1, k == 2,
                   $urandom_range(0, 3), $urandom, 1'b0, (k == 0) && ($urandom_range(0, 3) == 0));
        end
    endtask

    // Monitor: a cycle with StallM=0 retires one op at the next edge; otherwise a bubble.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL retire: unexpected W-stage write, queue empty");
                    end else begin
                        e = exp_q.pop_front();
                        chk("alu_w", ALUOutW, e.alu);
                        chk("rdata_w", ReadDataW, e.rdata);
                        chk("wreg_w", 32'(WriteRegW), 32'(e.wr));
                        chk("regwrite_w", 32'(RegWriteW), 32'(e.rw));
                        chk("memtoreg_w", 32'(MemtoRegW), 32'(e.mtr));
                        chk("buserr", 32'(BusErrM), 32'(e.berr));
                    end
                end else begin
                    chk("bubble_rw", 32'(RegWriteW), 32'h0);
                    chk("bubble_mtr", 32'(MemtoRegW), 32'h0);
                end
                pend = !StallM;
            end
        end
    end

    initial begin
        #2;
        chk("rst_req", 32'(DMemReq), 32'h0);
        chk("rst_stall", 32'(StallM), 32'h0);
        chk("rst_alu_w", ALUOutW, 32'h0);
        chk("rst_rw_w", 32'(RegWriteW), 32'h0);
        chk("rst_buserr", 32'(BusErrM), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        // ALU op, zero-wait load, store with 3 waits
        run_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        run_op(32'h100, 32'h55, 5'd7, 1'b1, 1'b1, 1'b0, 0, 32'hCAFEF00D, 1'b0, 1'b0);
        run_op(32'h200, 32'hA5A5A5A5, 5'd9, 1'b0, 1'b0, 1'b1, 3, 32'h0, 1'b0, 1'b0);
        // back-to-back loads
        run_op(32'h300, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2, 32'h11112222, 1'b0, 1'b0);
        run_op(32'h304, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 0, 32'h33334444, 1'b0, 1'b0);
        // timeout, then a stray late ack on a non-memory op
        run_op(32'h400, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        run_op(32'h77, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        rand_ops(20);
        // reset during the second wait cycle
        ALUOutM = 32'h500; WriteDataM = 32'h0; WriteRegM = 5'd14;
        RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0; DMemAck = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        MemtoRegM = 1'b0; MemWriteM = 1'b0;
        exp_q.delete();
        exp_berr = 1'b0;
        #1;
        chk("midrst_req", 32'(DMemReq), 32'h0);
        chk("midrst_stall", 32'(StallM), 32'h0);
        chk("midrst_alu_w", ALUOutW, 32'h0);
        chk("midrst_rdata_w", ReadDataW, 32'h0);
        chk("midrst_wreg_w", 32'(WriteRegW), 32'h0);
        chk("midrst_rw_w", 32'(RegWriteW), 32'h0);
        chk("midrst_mtr_w", 32'(MemtoRegW), 32'h0);
        chk("midrst_buserr", 32'(BusErrM), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(32'h600, 32'h0, 5'd15, 1'b1, 1'b1, 1'b0, 1, 32'h9ABCDEF0, 1'b0, 1'b0);
        rand_ops(20);
        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
